regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised 2-read/1-write register file; depth and width set independently.
//  Optional hardwired-zero register 0 and a sequenced bulk-clear engine.
//  Optional write-to-read bypass.
//  Sits in the datapath between decode and ALU; next generation of the fixed 32x32 file.
// PARAMETERS
//  WORD_LENGTH  32                  bits per register
//  DEPTH        32                  number of registers (any value >= 2, not only powers of 2)
//  NBITS        CeilLog2(DEPTH)     address width
//  ZERO_REG     1                   1: register 0 always reads 0 and ignores writes
// PORTS
//  clk          in   1              single clock, rising edge
//  reset        in   1              synchronous, active-low
//  Read_Reg1    in   NBITS          read address, port 1
//  Read_Reg2    in   NBITS          read address, port 2
//  Write_Reg    in   NBITS          write address
//  Write_Data   in   WORD_LENGTH    write data
//  Write        in   1              write enable
//  Clear        in   1              start bulk clear (level sampled on clk)
//  Read_Data1   out  WORD_LENGTH    data for Read_Reg1 (combinational)
//  Read_Data2   out  WORD_LENGTH    data for Read_Reg2 (combinational)
//  Busy         out  1              clear sequence in progress
//  Clear_Done   out  1              one-cycle pulse when clear completes
//  Write_Dropped out 1              one-cycle pulse: write request discarded
// BEHAVIOUR
//  - reset==0 at clk: all registers <= 0, FSM <= IDLE; Busy, Clear_Done, Write_Dropped <= 0.
//    Reset wins over every other input. Reset mid-clear aborts the clear; no Clear_Done.
//  - Write: when Write=1 in IDLE, reg[Write_Reg] <= Write_Data at clk.
//    Visible on reads the following cycle (unless bypass is enabled).
//  - Ignored writes (no error pulse):
//    - Write_Reg >= DEPTH.
//    - ZERO_REG=1 and Write_Reg==0.
//  - Reads: Read_Data = reg[Read_Reg] combinationally.
//    - Read_Reg >= DEPTH reads 0.
//    - ZERO_REG=1 with addr 0 reads 0.
//    - Both ports may address the same register.
//  - Clear FSM:
//    - IDLE -> CLEAR when Clear=1; ptr <= 0.
//    - CLEAR: reg[ptr] <= 0, ptr++ each cycle; Busy=1.
//      After ptr==DEPTH-1 is cleared -> DONE.
//    - DONE: Clear_Done=1 for exactly one cycle, Busy=0, then -> IDLE.
//    - Clear is ignored while in CLEAR or DONE.
//    - Clear takes DEPTH cycles of Busy, plus 1 cycle of DONE.
//  - Write during CLEAR or DONE: write is discarded; Write_Dropped=1 on the next cycle.
//  - Reads during clear return current contents: already-cleared entries read 0,
//    the rest read their old values.
//  - Width rules: ptr is NBITS wide. DEPTH-1 is the terminal count, so there is no wrap to an out-of-range index.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - If Write=1 is accepted, the address is valid and writable, and Read_RegN==Write_Reg,
//      then Read_DataN = Write_Data in the same cycle.
//    - Bypass never applies to register 0 when ZERO_REG=1, nor to dropped writes.
//  REGFILE_BYPASS_EN undefined: reads always return stored contents.
//    A write becomes visible one cycle later.
// STRUCTURE
//  Package regfile_pkg:
//    - CeilLog2 function.
//    - Clear-FSM state typedef {IDLE, CLEAR, DONE}.
//  Sub-module regfile_clear_fsm:
//    - Owns state and ptr.
//    - Outputs Busy, Clear_Done, clear_en, clear_addr, write_block.
//  Top: storage array, write decode, two read muxes, optional bypass.
// TESTING
//  1 Reset, then write 0xDEADBEEF to r5; read r5 on both ports next cycle -> 0xDEADBEEF; other regs 0.
//  2 ZERO_REG=1: write 0x1234 to r0 -> r0 reads 0; Write_Dropped stays 0.
//  3 Fill all 32 regs with the value i+1; assert Clear for 1 cycle.
//    -> Busy high for 32 cycles, then Clear_Done for 1 cycle, then all regs read 0.
//    A write to r3 in cycle 10 gives a Write_Dropped pulse and r3 stays 0.
//  4 Reset asserted at clear cycle 7 -> all regs 0 next cycle; Busy=0; no Clear_Done pulse.
//  5 DEPTH=20 (NBITS=5): write to r25 is ignored; reading r25 -> 0; r19 is writable.
//  6 With REGFILE_BYPASS_EN: write 0xA5A5A5A5 to r7 while Read_Reg1=7 -> same-cycle 0xA5A5A5A5.
//    Without the macro: old value this cycle, new value next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: address-width helper
// and the bulk-clear FSM state encoding.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Smallest n with 2**n >= value; callers guarantee value >= 2.
    function automatic int CeilLog2(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks a pointer over every register index, one per
// cycle, then emits a single-cycle done pulse. Blocks writes while active.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int NBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             clear_done_o,
    output logic             clear_en_o,
    output logic [NBITS-1:0] clear_addr_o,
    output logic             write_block_o
);

    // Terminal count is the last valid index, so ptr never leaves the array.
    localparam logic [NBITS-1:0] LAST_PTR = NBITS'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [NBITS-1:0] ptr_q, ptr_d;

    // State and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and output decode; Clear is only honoured from IDLE.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        busy_o        = 1'b0;
        clear_done_o  = 1'b0;
        clear_en_o    = 1'b0;
        write_block_o = 1'b1;
        case (state_q)
            IDLE: begin
                write_block_o = 1'b0;
                if (clear_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                busy_o     = 1'b1;
                clear_en_o = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + NBITS'(1);
                end
            end
            DONE: begin
                clear_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clear_addr_o = ptr_q;

endmodule

// File: rtl/regfile_multiport.sv
// 2-read / 1-write register file with optional hardwired-zero r0 and a
// sequenced bulk clear. Optional same-cycle write-to-read bypass is enabled
// by defining REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int DEPTH       = 32,
    parameter int NBITS       = CeilLog2(DEPTH),
    parameter int ZERO_REG    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NBITS-1:0]       Read_Reg1,
    input  logic [NBITS-1:0]       Read_Reg2,
    input  logic [NBITS-1:0]       Write_Reg,
    input  logic [WORD_LENGTH-1:0] Write_Data,
    input  logic                   Write,
    input  logic                   Clear,
    output logic [WORD_LENGTH-1:0] Read_Data1,
    output logic [WORD_LENGTH-1:0] Read_Data2,
    output logic                   Busy,
    output logic                   Clear_Done,
    output logic                   Write_Dropped
);

    // One extra bit so DEPTH itself is representable for the range check.
    localparam logic [NBITS:0] DEPTH_EXT = (NBITS + 1)'(DEPTH);

    logic [WORD_LENGTH-1:0] reg_q [DEPTH];
    logic                   write_dropped_q;
    logic                   clear_en;
    logic [NBITS-1:0]       clear_addr;
    logic                   write_block;
    logic                   waddr_valid;
    logic                   waddr_zero;
    logic                   write_accept;
    logic [DEPTH-1:0]       wen_vec;
    logic [DEPTH-1:0]       clr_vec;
    logic [WORD_LENGTH-1:0] rd1_store;
    logic [WORD_LENGTH-1:0] rd2_store;

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .NBITS (NBITS)
    ) u_clear_fsm (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (Clear),
        .busy_o        (Busy),
        .clear_done_o  (Clear_Done),
        .clear_en_o    (clear_en),
        .clear_addr_o  (clear_addr),
        .write_block_o (write_block)
    );

    assign waddr_valid  = ({1'b0, Write_Reg} < DEPTH_EXT);
    assign waddr_zero   = (ZERO_REG != 0) && (Write_Reg == '0);
    assign write_accept = Write && !write_block && waddr_valid && !waddr_zero;

    // Per-entry one-hot write and clear strobes.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_decode
            assign wen_vec[gi] = write_accept && (Write_Reg == NBITS'(gi));
            assign clr_vec[gi] = clear_en && (clear_addr == NBITS'(gi));
        end
    endgenerate

    // Storage update: reset and the clear engine take priority over writes
    // (writes are blocked while clearing, so they never actually collide).
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_vec[i]) begin
                    reg_q[i] <= '0;
                end else if (wen_vec[i]) begin
                    reg_q[i] <= Write_Data;
                end
            end
        end
    end

    // Flag a write that arrived while the clear engine owned the array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_dropped_q <= 1'b0;
        end else begin
            write_dropped_q <= Write && write_block;
        end
    end

    assign Write_Dropped = write_dropped_q;

    // Read muxes: out-of-range addresses and a hardwired r0 fall through to 0.
    always_comb begin
        rd1_store = '0;
        rd2_store = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                if (Read_Reg1 == NBITS'(i)) begin
                    rd1_store = reg_q[i];
                end
                if (Read_Reg2 == NBITS'(i)) begin
                    rd2_store = reg_q[i];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign Read_Data1 = (write_accept && (Read_Reg1 == Write_Reg)) ? Write_Data : rd1_store;
    assign Read_Data2 = (write_accept && (Read_Reg2 == Write_Reg)) ? Write_Data : rd2_store;
`else
    assign Read_Data1 = rd1_store;
    assign Read_Data2 = rd2_store;
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport: a vector table for
// basic write/read behaviour plus hand sequences for clear, reset abort,
// non-power-of-two depth and the bypass option.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rr1, rr2, wreg;
    logic [31:0] wdata;
    logic        wr, clr;
    logic [31:0] rd1, rd2, rd1_20, rd2_20;
    logic        busy, done, drop;
    logic        busy20, done20, drop20;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.WORD_LENGTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset),
        .Read_Reg1(rr1), .Read_Reg2(rr2), .Write_Reg(wreg),
        .Write_Data(wdata), .Write(wr), .Clear(clr),
        .Read_Data1(rd1), .Read_Data2(rd2),
        .Busy(busy), .Clear_Done(done), .Write_Dropped(drop)
    );

    regfile_multiport #(.WORD_LENGTH(32), .DEPTH(20), .ZERO_REG(1)) u_dut20 (
        .clk(clk), .reset(reset),
        .Read_Reg1(rr1), .Read_Reg2(rr2), .Write_Reg(wreg),
        .Write_Data(wdata), .Write(wr), .Clear(clr),
        .Read_Data1(rd1_20), .Read_Data2(rd2_20),
        .Busy(busy20), .Clear_Done(done20), .Write_Dropped(drop20)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;
    int busy20_cnt;
    logic [31:0] bypass_exp;

    initial begin
        tbl[0] = '{"wr_r5",      1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{"wr_r0_zero", 1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{"wr_r31",     1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd6,  32'hCAFEF00D, 32'h0};
        tbl[3] = '{"no_write",   1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[4] = '{"overwrite",  1'b1, 5'd5,  32'h11111111, 5'd5,  5'd0,  32'h11111111, 32'h0};

        reset = 1'b0; rr1 = '0; rr2 = '0; wreg = '0; wdata = '0; wr = 1'b0; clr = 1'b0;
        tick(); tick();
        reset = 1'b1;
        rr1 = 5'd5; rr2 = 5'd12;
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_drop", {31'b0, drop}, 32'd0);
        check("reset_r5", rd1, 32'h0);
        check("reset_r12", rd2, 32'h0);

        // Table: each write is visible through the read ports on the next cycle.
        for (int v = 0; v < 5; v++) begin
            wr = tbl[v].wr; wreg = tbl[v].waddr; wdata = tbl[v].wdata;
            rr1 = tbl[v].ra1; rr2 = tbl[v].ra2;
            tick();
            wr = 1'b0;
            #1;
            check({tbl[v].name, "_rd1"}, rd1, tbl[v].exp1);
            check({tbl[v].name, "_rd2"}, rd2, tbl[v].exp2);
            check({tbl[v].name, "_drop"}, {31'b0, drop}, 32'd0);
        end

        // DEPTH=20: r25 is out of range and ignored, r19 is the last valid entry.
        wr = 1'b1; wreg = 5'd25; wdata = 32'h25252525; tick();
        wreg = 5'd19; wdata = 32'h19191919; tick();
        wr = 1'b0; rr1 = 5'd25; rr2 = 5'd19;
        #1;
        check("d20_r25", rd1_20, 32'h0);
        check("d20_r19", rd2_20, 32'h19191919);
        check("d20_drop", {31'b0, drop20}, 32'd0);
        check("d32_r25", rd1, 32'h25252525);

        // Bypass: same-cycle forwarding only when the option is built in.
        wr = 1'b1; wreg = 5'd7; wdata = 32'h00000077; tick();
        wdata = 32'hA5A5A5A5; rr1 = 5'd7; rr2 = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 32'hA5A5A5A5;
`else
        bypass_exp = 32'h00000077;
`endif
        check("byp_same_cycle", rd1, bypass_exp);
        tick();
        wr = 1'b0;
        #1;
        check("byp_next_cycle", rd1, 32'hA5A5A5A5);
        wr = 1'b1; wreg = 5'd0; wdata = 32'hFFFFFFFF; rr2 = 5'd0;
        #1;
        check("byp_r0_never", rd2, 32'h0);
        tick();
        wr = 1'b0;

        // Fill r0..r31 with i+1 (r0 write ignored), then run a full clear.
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; wreg = 5'(i); wdata = 32'(i + 1);
            tick();
        end
        wr = 1'b0;
        rr1 = 5'd20; rr2 = 5'd3;
        #1;
        check("fill_r20", rd1, 32'd21);
        check("fill_r3", rd2, 32'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < 36; k++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = k; end
            if (k == 5) begin
                rr1 = 5'd2; rr2 = 5'd20;
                #1;
                check("mid_clear_r2", rd1, 32'h0);
                check("mid_clear_r20", rd2, 32'd21);
            end
            if (k == 10) begin
                wr = 1'b1; wreg = 5'd3; wdata = 32'h33333333;
            end
            if (k == 11) begin
                wr = 1'b0;
                check("clear_drop_pulse", {31'b0, drop}, 32'd1);
            end
            if (k == 12) check("clear_drop_end", {31'b0, drop}, 32'd0);
            tick();
        end
        check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clear_done_count", 32'(done_cnt), 32'd1);
        check("clear_done_pos", 32'(done_at), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            #1;
            check($sformatf("cleared_r%0d", i), rd1, 32'h0);
        end
        rr2 = 5'd3;
        #1;
        check("cleared_r3_after_drop", rd2, 32'h0);

        // Reset during clear aborts it: everything zero, no done pulse.
        for (int i = 1; i <= 8; i++) begin
            wr = 1'b1; wreg = 5'(i); wdata = 32'(32'h100 + i);
            tick();
        end
        wr = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (done) done_cnt++;
            tick();
        end
        reset = 1'b0;
        tick();
        rr1 = 5'd8; rr2 = 5'd7;
        #1;
        check("abort_r8", rd1, 32'h0);
        check("abort_r7", rd2, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        reset = 1'b1;
        busy20_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            if (busy) busy20_cnt++;
            tick();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_busy", 32'(busy20_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
